// File: rtl/result_tx_if.sv
// Handshake and serial-line bundle between a result producer and the
// result_tx UART reporter.
interface result_tx_if #(
  parameter int NB_RES = 8
);
  logic              start;
  logic [5:0]        op;
  logic [NB_RES-1:0] res;
  logic              tx;
  logic              busy;
  logic              done;

  // start is level-sampled: a transfer is accepted on any edge where the
  // block is idle and start=1; busy stays high until the edge that pulses done.
  modport master (output start, output op, output res,
                  input  tx,    input  busy, input done);
  modport slave  (input  start, input  op,   input res,
                  output tx,    output busy, output done);
endinterface

// File: rtl/result_tx.sv
// Serialises one opcode/result pair as two back-to-back 8N1 UART frames:
// frame 0 carries {2'b00, op}, frame 1 carries res.
module result_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int NB_RES       = 8
) (
  input  logic        clk,
  input  logic        rst,
  result_tx_if.slave  bus,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam int             BW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0]  BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  state_t            state_q, state_n;
  logic              frame_q, frame_n;
  logic [BW-1:0]     baud_q, baud_n;
  logic [2:0]        bit_q, bit_n;
  logic [5:0]        op_q, op_n;
  logic [NB_RES-1:0] res_q, res_n;
  logic              tx_q, tx_n;
  logic              busy_q, busy_n;
  logic              done_q, done_n;

  logic [NB_RES-1:0] payload;
  logic              bit_end;
  logic [2:0]        bit_inc;

  // Payload is built only from the latched copies so bus changes mid-transfer
  // cannot leak onto the line.
  assign payload = frame_q ? res_q : {{(NB_RES-6){1'b0}}, op_q};
  assign bit_end = (baud_q == BAUD_LAST);
  assign bit_inc = bit_q + 3'd1;

  always_comb begin
    state_n = state_q;
    frame_n = frame_q;
    baud_n  = baud_q;
    bit_n   = bit_q;
    op_n    = op_q;
    res_n   = res_q;
    tx_n    = tx_q;
    busy_n  = busy_q;
    done_n  = 1'b0;

    case (state_q)
      IDLE: begin
        tx_n   = 1'b1;
        busy_n = 1'b0;
        if (bus.start) begin
          op_n    = bus.op;
          res_n   = bus.res;
          frame_n = 1'b0;
          baud_n  = '0;
          bit_n   = '0;
          tx_n    = 1'b0;
          busy_n  = 1'b1;
          state_n = START;
        end
      end

      START: begin
        if (bit_end) begin
          baud_n  = '0;
          bit_n   = '0;
          tx_n    = payload[0];
          state_n = DATA;
        end else begin
          baud_n = baud_q + BW'(1);
        end
      end

      DATA: begin
        if (bit_end) begin
          baud_n = '0;
          if (bit_q == 3'd7) begin
            bit_n   = '0;
            tx_n    = 1'b1;
            state_n = STOP;
          end else begin
            bit_n = bit_inc;
            tx_n  = payload[bit_inc];
          end
        end else begin
          baud_n = baud_q + BW'(1);
        end
      end

      STOP: begin
        if (bit_end) begin
          baud_n = '0;
          if (!frame_q) begin
            // Result frame follows the opcode frame with no idle gap.
            frame_n = 1'b1;
            tx_n    = 1'b0;
            state_n = START;
          end else begin
            frame_n = 1'b0;
            tx_n    = 1'b1;
            busy_n  = 1'b0;
            done_n  = 1'b1;
            state_n = IDLE;
          end
        end else begin
          baud_n = baud_q + BW'(1);
        end
      end

      default: begin
        state_n = IDLE;
        tx_n    = 1'b1;
        busy_n  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      frame_q <= 1'b0;
      baud_q  <= '0;
      bit_q   <= '0;
      op_q    <= '0;
      res_q   <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      frame_q <= frame_n;
      baud_q  <= baud_n;
      bit_q   <= bit_n;
      op_q    <= op_n;
      res_q   <= res_n;
      tx_q    <= tx_n;
      busy_q  <= busy_n;
      done_q  <= done_n;
    end
  end

  assign bus.tx    = tx_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_result_tx.sv
// Directed bench for result_tx at CLKS_PER_BIT=4: every cycle of each
// transfer is checked as {tx, busy, done} against hand-computed frames.
module tb_result_tx;

  localparam int CPB = 4;

  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;

  result_tx_if #(.NB_RES(8)) bus ();

  result_tx #(.CLKS_PER_BIT(CPB), .NB_RES(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Scoreboard
  int         n_pass  = 0;
  int         n_total = 0;
  logic [2:0] exp_q[$];

  task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask

  // Frames written first-transmitted bit at the MSB: start, d0..d7, stop.
  typedef struct {
    logic [5:0] op;
    logic [7:0] res;
    logic [9:0] f0;
    logic [9:0] f1;
  } vec_t;

  vec_t vecs[4];

  task automatic load_expect(input logic [9:0] f0, input logic [9:0] f1);
    logic [19:0] seq;
    seq = {f0, f1};
    exp_q.delete();
    for (int b = 0; b < 20; b++)
      for (int k = 0; k < CPB; k++)
        exp_q.push_back({seq[19-b], 1'b1, 1'b0});
  endtask

  // Called at a negedge where start is already high and the DUT is idle:
  // the next posedge accepts the transfer.
  task automatic check_frames(input string tag, input logic [9:0] f0, input logic [9:0] f1,
                              input bit keep_start, input bit mutate);
    logic [2:0] e;
    load_expect(f0, f1);
    for (int c = 0; c < 20*CPB; c++) begin
      @(negedge clk);
      if (c == 0 && !keep_start) bus.start = 1'b0;
      if (mutate && c == 10) begin
        bus.op  = 6'($urandom);
        bus.res = 8'($urandom);
      end
      if (mutate && c == 30) bus.start = 1'b1;
      if (mutate && c == 31) bus.start = 1'b0;
      e = exp_q.pop_front();
      check($sformatf("%s c%0d", tag, c), {bus.tx, bus.busy, bus.done}, e);
    end
    @(negedge clk);
    check($sformatf("%s done", tag), {bus.tx, bus.busy, bus.done}, 3'b101);
    if (!keep_start) begin
      @(negedge clk);
      check($sformatf("%s idle", tag), {bus.tx, bus.busy, bus.done}, 3'b100);
      check($sformatf("%s idle_state", tag), {1'b0, dbg_state}, 3'b000);
    end
  endtask

  // Driver / test sequence
  initial begin
    logic [2:0] e;

    vecs[0] = '{op: 6'b100000, res: 8'hA5, f0: 10'b0000001001, f1: 10'b0101001011};
    vecs[1] = '{op: 6'b111111, res: 8'h00, f0: 10'b0111111001, f1: 10'b0000000001};
    vecs[2] = '{op: 6'b000001, res: 8'hFF, f0: 10'b0100000001, f1: 10'b0111111111};
    vecs[3] = '{op: 6'b101010, res: 8'h3C, f0: 10'b0010101001, f1: 10'b0001111001};

    rst       = 1'b1;
    bus.start = 1'b0;
    bus.op    = '0;
    bus.res   = '0;

    // Reset held two cycles, then idle
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check($sformatf("reset c%0d", c), {bus.tx, bus.busy, bus.done}, 3'b100);
    end
    check("reset_state", {1'b0, dbg_state}, 3'b000);
    rst = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check($sformatf("post_reset c%0d", c), {bus.tx, bus.busy, bus.done}, 3'b100);
    end

    // Table-driven single transfers
    for (int i = 0; i < 4; i++) begin
      bus.op    = vecs[i].op;
      bus.res   = vecs[i].res;
      bus.start = 1'b1;
      check_frames($sformatf("vec%0d", i), vecs[i].f0, vecs[i].f1, 1'b0, 1'b0);
    end

    // Bus changes and a stray start during busy must not disturb the line
    bus.op    = vecs[0].op;
    bus.res   = vecs[0].res;
    bus.start = 1'b1;
    check_frames("mutate", vecs[0].f0, vecs[0].f1, 1'b0, 1'b1);

    // start held high: back-to-back transfers with one idle-high cycle
    bus.op    = vecs[3].op;
    bus.res   = vecs[3].res;
    bus.start = 1'b1;
    check_frames("b2b_a", vecs[3].f0, vecs[3].f1, 1'b1, 1'b0);
    check_frames("b2b_b", vecs[3].f0, vecs[3].f1, 1'b0, 1'b0);

    // Reset at cycle 25 of a transfer aborts it without done
    bus.op    = vecs[0].op;
    bus.res   = vecs[0].res;
    bus.start = 1'b1;
    load_expect(vecs[0].f0, vecs[0].f1);
    for (int c = 0; c <= 25; c++) begin
      @(negedge clk);
      if (c == 0) bus.start = 1'b0;
      e = exp_q.pop_front();
      check($sformatf("abort c%0d", c), {bus.tx, bus.busy, bus.done}, e);
    end
    rst = 1'b1;
    @(negedge clk);
    check("abort_after_rst", {bus.tx, bus.busy, bus.done}, 3'b100);
    check("abort_state", {1'b0, dbg_state}, 3'b000);
    // First edge with rst low accepts start
    rst       = 1'b0;
    bus.op    = vecs[2].op;
    bus.res   = vecs[2].res;
    bus.start = 1'b1;
    check_frames("after_abort", vecs[2].f0, vecs[2].f1, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
